// File: rtl/zymason_scan_sched.sv
// Digit scan / write-strobe sequencer for a NUM_DIGITS-entry digit store and display bus.
// Scan mode rotates a one-hot digit enable with dwell and blanking; write mode emits nibble strobes.
module zymason_scan_sched #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_W      = 5,
  parameter int BLANK_CYCLES = 2,
  localparam int CW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode_wr,
  input  logic                  nib_sel,
  input  logic                  commit,
  input  logic                  tick,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  wr_lo,
  output logic                  wr_hi,
  output logic [CW-1:0]         cursor,
  output logic                  in_write
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CUR_LAST   = CW'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_BLANK,
    S_WEDIT,
    S_WSTRB
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cursor_q, cursor_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic                 commit_q, commit_d;
  logic                 nib_q, nib_d;
  logic                 cedge;
  logic [DWELL_W-1:0]   dwell_last;

  // Explicit wrap keeps the cursor correct for non-power-of-2 digit counts.
  function automatic logic [CW-1:0] cur_inc(input logic [CW-1:0] c);
    return (c == CUR_LAST) ? '0 : c + CW'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cursor_q <= '0;
      cnt_q    <= '0;
      blank_q  <= '0;
      commit_q <= 1'b0;
      nib_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      blank_q  <= blank_d;
      commit_q <= commit_d;
      nib_q    <= nib_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    nib_d      = nib_q;
    commit_d   = commit;
    cedge      = commit & ~commit_q;
    // dwell of 0 behaves as 1, so the last count index saturates at 0.
    dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    case (state_q)
      S_IDLE: begin
        cursor_d = '0;
        cnt_d    = '0;
        state_d  = mode_wr ? S_WEDIT : S_SHOW;
      end
      S_SHOW: begin
        if (mode_wr) begin
          state_d  = S_WEDIT;
          cursor_d = '0;
          cnt_d    = '0;
        end else if (tick && (cnt_q >= dwell_last)) begin
          state_d  = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
          cursor_d = cur_inc(cursor_q);
          cnt_d    = '0;
          blank_d  = '0;
        end else if (tick) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      S_BLANK: begin
        if (mode_wr) begin
          state_d  = S_WEDIT;
          cursor_d = '0;
          cnt_d    = '0;
          blank_d  = '0;
        end else if (blank_q == BLANK_LAST) begin
          state_d = S_SHOW;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      S_WEDIT: begin
        if (!mode_wr) begin
          state_d  = S_SHOW;
          cursor_d = '0;
          cnt_d    = '0;
        end else if (cedge) begin
          state_d = S_WSTRB;
          nib_d   = nib_sel;
        end
      end
      S_WSTRB: begin
        state_d = S_WEDIT;
        if (nib_q) cursor_d = cur_inc(cursor_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dig_en   = '0;
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    in_write = 1'b0;
    cursor   = cursor_q;
    if (state_q == S_SHOW || state_q == S_WEDIT || state_q == S_WSTRB)
      dig_en = NUM_DIGITS'(1) << cursor_q;
    if (state_q == S_WSTRB) begin
      wr_lo = ~nib_q;
      wr_hi = nib_q;
    end
    in_write = (state_q == S_WEDIT) || (state_q == S_WSTRB);
  end

endmodule

// File: tb/tb_zymason_scan_sched.sv
// Randomised and directed bench for zymason_scan_sched against a behavioural model.
module tb_zymason_scan_sched;

  localparam int N     = 4;
  localparam int DW    = 5;
  localparam int BLANK = 2;
  localparam int CW    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode_wr = 1'b0;
  logic          nib_sel = 1'b0;
  logic          commit = 1'b0;
  logic          tick = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  dig_en;
  logic          wr_lo;
  logic          wr_hi;
  logic [CW-1:0] cursor;
  logic          in_write;

  int total = 0;
  int bad   = 0;

  // Behavioural model: write mode flag, pending strobe kind, blanking countdown, ticks seen.
  bit m_started;
  bit m_wr;
  int m_strobe;      // 0 none, 1 low nibble, 2 high nibble
  int m_cur;
  int m_ticks;
  int m_blank_left;
  bit m_prev_commit;

  zymason_scan_sched #(.NUM_DIGITS(N), .DWELL_W(DW), .BLANK_CYCLES(BLANK)) dut (
    .clock(clock), .reset(reset), .mode_wr(mode_wr), .nib_sel(nib_sel),
    .commit(commit), .tick(tick), .dwell(dwell), .dig_en(dig_en),
    .wr_lo(wr_lo), .wr_hi(wr_hi), .cursor(cursor), .in_write(in_write)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_wr = 0; m_strobe = 0; m_cur = 0;
    m_ticks = 0; m_blank_left = 0; m_prev_commit = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    int d;
    edge_seen = commit && !m_prev_commit;
    m_prev_commit = commit;
    if (!m_started) begin
      m_started = 1; m_wr = mode_wr; m_cur = 0; m_ticks = 0;
    end else if (m_strobe != 0) begin
      if (m_strobe == 2) m_cur = (m_cur + 1) % N;
      m_strobe = 0;
    end else if (m_wr) begin
      if (!mode_wr) begin
        m_wr = 0; m_cur = 0; m_ticks = 0;
      end else if (edge_seen) begin
        m_strobe = nib_sel ? 2 : 1;
      end
    end else if (mode_wr) begin
      m_wr = 1; m_cur = 0; m_ticks = 0; m_blank_left = 0;
    end else if (m_blank_left > 0) begin
      m_blank_left--;
    end else if (tick) begin
      d = (dwell == 0) ? 1 : int'(dwell);
      if (m_ticks + 1 >= d) begin
        m_cur = (m_cur + 1) % N; m_ticks = 0; m_blank_left = BLANK;
      end else begin
        m_ticks++;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_en;
    exp_en = (m_started && m_blank_left == 0) ? N'(1) << m_cur : '0;
    chk("dig_en", 32'(dig_en), 32'(exp_en));
    chk("wr_lo", 32'(wr_lo), 32'(m_strobe == 1));
    chk("wr_hi", 32'(wr_hi), 32'(m_strobe == 2));
    chk("cursor", 32'(cursor), 32'(m_cur));
    chk("in_write", 32'(in_write), 32'(m_wr));
  endtask

  // Inputs are set here (#1 after an edge), then one active edge is taken and checked.
  task automatic cyc(input bit mw, input bit ns, input bit cm, input bit tk, input int dw);
    mode_wr = mw; nib_sel = ns; commit = cm; tick = tk; dwell = DW'(dw);
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_dig_en", 32'(dig_en), 32'h0);
    chk("rst_wr_lo", 32'(wr_lo), 32'h0);
    chk("rst_wr_hi", 32'(wr_hi), 32'h0);
    chk("rst_in_write", 32'(in_write), 32'h0);
    chk("rst_cursor", 32'(cursor), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_hold_dig_en", 32'(dig_en), 32'h0);
    model_reset();
    reset = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    int strobes;
    int found;
    bit mw;
    int dw;
    model_reset();
    mode_wr = 0; commit = 0; tick = 0; dwell = 3;

    // Reset and first scan cycles.
    #2;
    do_reset();

    // Continuous ticks, dwell 3, full wrap twice.
    for (int i = 0; i < 45; i++) cyc(0, 0, 0, 1, 3);

    // dwell 0 with sparse ticks, then dwell 7 lowered to 1 mid-digit.
    for (int i = 0; i < 24; i++) cyc(0, 0, 0, (i % 4) == 3, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, (i % 4) == 3, 7);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, (i % 4) == 3, 1);

    // Write mode: lo then hi per digit, eight digits so the cursor wraps.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 3);
    for (int w = 0; w < 8; w++) begin
      cyc(1, 0, 1, 0, 3);
      cyc(1, 0, 0, 0, 3);
      cyc(1, 1, 1, 0, 3);
      cyc(1, 1, 0, 0, 3);
      cyc(1, 1, 0, 0, 3);
    end

    // Held commit gives exactly one strobe.
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1, 0, 3);
      strobes += int'(wr_lo) + int'(wr_hi);
    end
    chk("held_commit_strobes", 32'(strobes), 32'd1);
    cyc(1, 0, 0, 0, 3);
    cyc(1, 0, 0, 0, 3);

    // mode_wr falls together with a commit edge: dropped.
    cyc(1, 1, 1, 0, 3);
    cyc(1, 1, 0, 0, 3);
    cyc(1, 1, 0, 0, 3);
    cyc(0, 1, 1, 0, 3);
    chk("drop_wr_hi", 32'(wr_hi), 32'h0);
    chk("drop_in_write", 32'(in_write), 32'h0);
    cyc(0, 0, 0, 0, 3);

    // Randomised mix of scan and write activity.
    mw = 0; dw = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) mw = !mw;
      if ($urandom_range(0, 29) == 0) dw = $urandom_range(0, 6);
      cyc(mw, $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1), dw);
    end

    // Async reset while a high-nibble strobe is active.
    cyc(1, 0, 0, 0, 3);
    cyc(1, 0, 0, 0, 3);
    cyc(1, 1, 1, 0, 3);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (m_strobe == 2) found = 1;
      else cyc(1, 1, 0, 0, 3);
    end
    chk("wstrb_reached", 32'(found), 32'd1);
    chk("pre_rst_wr_hi", 32'(wr_hi), 32'd1);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
